mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
//   MULT/MULTU use shift-add, and DIV/DIVU use restoring division.
//   Each takes one result bit per clock.
//   Signed operations run on magnitudes; the signs are fixed up in a final cycle.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, op[1:0]        launch (IDLE only); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcA, srcB            operands rs / rt
//   hiWrite, loWrite,
//   writeData             MTHI / MTLO, honoured only in IDLE without start
//   busy, done, divZero   in-flight flag, completion pulse, divide-by-zero pulse
//   hi, lo                HI / LO registers
//
// state  | meaning
// IDLE   | waiting for start, MTHI/MTLO accepted
// MUL    | shift-add step, one multiplier bit per clock
// DIV    | restoring step, one quotient bit per clock
// FIX    | sign correction, write hi/lo, pulse done
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;       // multiplicand / divisor magnitude
   logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;   // multiplier -> product low half / dividend -> quotient
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div0_q, div0_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             divzero_q, divzero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign a_neg = ~op[0] & srcA[WIDTH-1];
   assign b_neg = ~op[0] & srcB[WIDTH-1];
   assign mag_a = a_neg ? -srcA : srcA;
   assign mag_b = b_neg ? -srcB : srcB;

   // Add the multiplicand into the high half when the current multiplier bit is set.
   // Then shift {carry, acc, quo} right by one.
   assign mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, a_q} : '0);

   // When the trial subtraction succeeds, the result is below the divisor.
   // The low WIDTH bits of the difference are therefore exact.
   assign div_shift = {acc_q, quo_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, a_q};
   assign div_sub   = div_shift[WIDTH-1:0] - a_q;

   assign prod_fix = neg_res_q ? -{acc_q, quo_q} : {acc_q, quo_q};
   assign quo_fix  = neg_res_q ? -quo_q : quo_q;
   assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d  = op[1];
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               a_d       = mag_b;
               acc_d     = '0;
               quo_d     = mag_a;
               cnt_d     = '0;
               busy_d    = 1'b1;
               div0_d    = 1'b0;
               if (op[1] && (srcB == '0)) begin
                  // The raw dividend is kept so that it can be reported in hi.
                  div0_d  = 1'b1;
                  quo_d   = srcA;
                  state_d = S_FIX;
               end else begin
                  state_d = op[1] ? S_DIV : S_MUL;
               end
            end else begin
               if (hiWrite) hi_d = writeData;
               if (loWrite) lo_d = writeData;
            end
         end
         S_MUL: begin
            acc_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_DIV: begin
            acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], div_ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_FIX: begin
            if (div0_q) begin
               hi_d = quo_q;
               lo_d = '1;
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            divzero_d = div0_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         acc_q     <= '0;
         quo_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         quo_q     <= quo_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign divZero = divzero_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit.
// A behavioural model computes results with native 64-bit arithmetic.
// It counts down the edges remaining until completion and is checked against the DUT every cycle.
// Literal checks pin the model to known answers.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srcA, srcB, writeData;
   logic        hiWrite, loWrite;
   logic        busy, done, divZero;
   logic [31:0] hi, lo;

   int checks = 0;
   int fails  = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .srcA(srcA), .srcB(srcB), .hiWrite(hiWrite), .loWrite(loWrite),
      .writeData(writeData), .busy(busy), .done(done), .divZero(divZero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl, output logic dz);
      longint     sp, sq, sr;
      logic [63:0] up;
      dz = 1'b0;
      rh = '0;
      rl = '0;
      case (o)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            rh = sp[63:32];
            rl = sp[31:0];
         end
         2'b01: begin
            up = {32'b0, a} * {32'b0, b};
            rh = up[63:32];
            rl = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               rh = a;
               rl = 32'hFFFFFFFF;
               dz = 1'b1;
            end else if (o == 2'b10) begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               rl = sq[31:0];
               rh = sr[31:0];
            end else begin
               rl = a / b;
               rh = a % b;
            end
         end
      endcase
   endfunction

   // Behavioural model
   logic        m_busy, m_done, m_dz, p_dz, chk_en;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   int          m_rem;
   logic [31:0] t_hi, t_lo;
   logic        t_dz;

   initial begin
      chk_en = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_rem = 0;
      p_dz = 1'b0; p_hi = '0; p_lo = '0;
   end

   always @(posedge clk) begin
      if (reset) begin
         chk_en <= 1'b1;
         m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
         m_hi <= '0; m_lo <= '0; m_rem <= 0;
      end else begin
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         if (m_busy) begin
            if (m_rem == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_dz   <= p_dz;
               m_hi   <= p_hi;
               m_lo   <= p_lo;
            end
            m_rem <= m_rem - 1;
         end else if (start) begin
            ref_result(op, srcA, srcB, t_hi, t_lo, t_dz);
            p_hi   <= t_hi;
            p_lo   <= t_lo;
            p_dz   <= t_dz;
            m_rem  <= t_dz ? 1 : 33;
            m_busy <= 1'b1;
         end else begin
            if (hiWrite) m_hi <= writeData;
            if (loWrite) m_lo <= writeData;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'b0, busy}, {31'b0, m_busy});
         check("done", {31'b0, done}, {31'b0, m_done});
         check("divZero", {31'b0, divZero}, {31'b0, m_dz});
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
      end
   end

   // Called at a negedge; start is sampled on the next posedge (E0).
   // Returns at the negedge on which done is visible.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input bit noise);
      int n;
      op = o; srcA = a; srcB = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 60) begin
         if (noise) begin
            start     = 1'($urandom_range(0, 1));
            op        = 2'($urandom);
            srcA      = $urandom;
            srcB      = $urandom;
            hiWrite   = 1'($urandom_range(0, 1));
            loWrite   = 1'($urandom_range(0, 1));
            writeData = $urandom;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
      check("latency", 32'(n), 32'(exp_lat));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
      hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b0;

      // MULTU and MULT of all-ones
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
      check("mult_hi", hi, 32'h0);
      check("mult_lo", lo, 32'h1);

      // Signed and unsigned division
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 33, 1'b0);
      check("div_neg_lo", lo, 32'hFFFFFFFD);
      check("div_neg_hi", hi, 32'hFFFFFFFF);
      run_op(2'b11, 32'd7, 32'd2, 33, 1'b0);
      check("divu_lo", lo, 32'd3);
      check("divu_hi", hi, 32'd1);

      // Divide by zero completes after one edge
      run_op(2'b11, 32'h12345678, 32'd0, 1, 1'b0);
      check("div0_flag", {31'b0, divZero}, 32'd1);
      check("div0_hi", hi, 32'h12345678);
      check("div0_lo", lo, 32'hFFFFFFFF);

      // Most negative divided by -1
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0);
      check("ovf_lo", lo, 32'h80000000);
      check("ovf_hi", hi, 32'h0);
      check("ovf_flag", {31'b0, divZero}, 32'd0);

      // A start or hiWrite while busy is ignored
      @(negedge clk);
      op = 2'b00; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; hiWrite = 1'b1; writeData = 32'hDEAD; srcA = 32'd99;
      @(negedge clk);
      start = 1'b0; hiWrite = 1'b0;
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("busy_ign_done", {31'b0, done}, 32'd1);
      check("busy_ign_hi", hi, 32'h0);
      check("busy_ign_lo", lo, 32'd15);
      @(negedge clk);
      hiWrite = 1'b1; writeData = 32'hDEAD;
      @(negedge clk);
      hiWrite = 1'b0;
      check("mthi", hi, 32'h0000DEAD);

      // Reset in the middle of a division
      op = 2'b11; srcA = 32'd1000; srcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      run_op(2'b01, 32'd2, 32'd3, 33, 1'b0);
      check("post_rst_lo", lo, 32'd6);

      // Randomised operations, some with noise while busy, some with MTHI/MTLO between
      for (int i = 0; i < 40; i++) begin
         r_op = 2'($urandom);
         r_a  = $urandom;
         case ($urandom_range(0, 7))
            0:       r_b = 32'd0;
            1:       r_b = 32'($urandom_range(1, 9));
            2:       r_b = 32'hFFFFFFFF;
            default: r_b = $urandom;
         endcase
         if (i % 5 == 0) r_a = 32'h80000000;
         run_op(r_op, r_a, r_b, (r_op[1] && r_b == 32'd0) ? 1 : 33, 1'(i % 2));
         if ($urandom_range(0, 2) == 0) begin
            hiWrite = 1'($urandom_range(0, 1));
            loWrite = 1'($urandom_range(0, 1));
            writeData = $urandom;
            @(negedge clk);
            hiWrite = 1'b0; loWrite = 1'b0;
         end
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
